dpram_pingpong_buffer: RTL and testbench
========================================

# dpram_pingpong_buffer

Multi-bank ping-pong buffer built on simple dual-port RAM storage, for the layer engines' feature-map and weight staging. A producer fills one bank while a consumer drains previously completed banks. Bank ownership passes through explicit done/ready handshakes, and read data returns through a parametrised-latency pipeline with a valid strobe. Banks, width, depth and read latency are all parameters.

## Interface
- DW, 64: data bits per word; multiple of 8
- AW, 8: word address bits within one bank
- DEPTH, 256: words per bank; ≤ 2^AW
- N_BANK, 2: number of banks; 1..8
- N_DELAY, 1: read latency in cycles; 1..4
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of bank state; does not clear memory
- wr_en  in  1  write strobe into the current write bank
- wr_addr  in  AW  word address within the write bank
- wr_data  in  DW  write data
- wr_be  in  DW/8  byte enables; bit i covers wr_data[8i+7:8i]
- wr_done  in  1  marks the current write bank full and advances
- wr_ready  out  1  a free bank is available to the producer
- wr_bank  out  BW  index of the current write bank; BW = max(1, clog2(N_BANK))
- rd_en  in  1  read strobe from the current read bank
- rd_addr  in  AW  word address within the read bank
- rd_done  in  1  releases the current read bank and advances
- rd_ready  out  1  at least one full bank is available to the consumer
- rd_bank  out  BW  index of the current read bank
- rd_data  out  DW  read data
- rd_valid  out  1  rd_data is valid this cycle
- fill_cnt  out  BW+1  number of full banks, 0..N_BANK

## Operation
- State: wr_ptr, rd_ptr (0..N_BANK-1, wrapping modulo N_BANK), fill_cnt.
- wr_ready = (fill_cnt < N_BANK). rd_ready = (fill_cnt > 0).
- Write: when wr_en && wr_ready, write bytes where wr_be=1 to physical address {wr_ptr, wr_addr}. Bytes where wr_be=0 keep their contents. When wr_ready=0, wr_en is ignored and memory is unchanged.
- wr_done when wr_ready: wr_ptr advances modulo N_BANK; fill_cnt increments. wr_done when wr_ready=0 is ignored.
- Read: when rd_en && rd_ready, read {rd_ptr, rd_addr}. rd_en when rd_ready=0 is ignored and injects no valid.
- rd_done when rd_ready: rd_ptr advances modulo N_BANK; fill_cnt decrements. rd_done when rd_ready=0 is ignored.
- Accepted wr_done and rd_done in the same cycle: both pointers advance and fill_cnt is unchanged.
- wr_en with wr_done in the same cycle: the write lands in the old bank, then the bank advances. rd_en with rd_done behaves the same way for reads.
- wr_addr or rd_addr ≥ DEPTH: a write is dropped. A read still produces rd_valid, with rd_data undefined.
- Producer and consumer never share a bank, so there is no read/write collision case.
- flush: wr_ptr, rd_ptr and fill_cnt go to 0 and the valid pipeline clears. Memory is retained. flush takes priority over done strobes in the same cycle.
- Reads already in the pipeline complete with captured data even if rd_done releases the bank and it is rewritten.

## Timing
- Reset values: wr_ptr=rd_ptr=0, fill_cnt=0, wr_ready=1, rd_ready=0, wr_bank=0, rd_bank=0, rd_valid=0, rd_data=0. Memory contents are not reset.
- Read latency: rd_en accepted at cycle t gives rd_valid=1 and data at t+N_DELAY. rd_data holds its value when rd_valid=0.
- Fully pipelined: one read per cycle sustained, one write per cycle sustained.
- The flag outputs (wr_ready, rd_ready, fill_cnt, wr_bank, rd_bank) are registered and update the cycle after the accepted done strobe.
- A word written at cycle t is readable by a read at t+1 or later, once its bank has been handed over.
- Reset asserted mid-operation clears all state immediately. In-flight reads are discarded with no rd_valid.

## Structure
- Shared package holds: bank-index width function (clog2 with minimum 1), N_DELAY bounds, and a DW%8 check constant. Illegal parameters trigger elaboration-time checks.
- One sub-module, dpram_be_bank_mem: a behavioural N_BANK*DEPTH × DW array with byte-enable writes and a registered read port (first stage). The remaining N_DELAY-1 stages and valid shift register live in the top.
- The top holds the pointer/count control and the read pipeline.

## Test plan
- N_BANK=2, N_DELAY=1: write 0..255 to bank 0, assert wr_done -> wr_bank=1, fill_cnt=1, rd_ready=1. Read addr 5 -> rd_valid and rd_data=5 one cycle later.
- N_BANK=2: fill both banks -> wr_ready=0. An extra wr_en to addr 0 with data 0xFF -> memory unchanged. An extra wr_done -> fill_cnt stays 2.
- Accepted wr_done and rd_done in the same cycle with fill_cnt=1 -> fill_cnt stays 1, both pointers advance. Pointers wrap from N_BANK-1 to 0.
- wr_be=0x0F with data 0xAAAA_AAAA_BBBB_BBBB over 0x1111_1111_2222_2222 -> readback 0x1111_1111_BBBB_BBBB.
- N_DELAY=3: back-to-back rd_en on addrs 0,1,2 -> rd_valid high on cycles t+3..t+5 with matching data. rd_en while rd_ready=0 -> no rd_valid.
- flush with fill_cnt=2 -> all pointers 0, wr_ready=1, rd_ready=0. rstn pulse mid-read burst -> rd_valid=0 with no late valids.

Source files
------------

// File: rtl/dpram_pingpong_buffer_pkg.sv
// dpram_pingpong_buffer_pkg: shared sizing helpers and parameter bounds for the ping-pong buffer
package dpram_pingpong_buffer_pkg;
  localparam int N_DELAY_MIN = 1;
  localparam int N_DELAY_MAX = 4;
  localparam int N_BANK_MAX = 8;
  function automatic int bank_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic bit dw_bytes_ok(input int dw);
    return (dw > 0) && ((dw % 8) == 0);
  endfunction
endpackage

// File: rtl/dpram_be_bank_mem.sv
// dpram_be_bank_mem: flat multi-bank word array with byte-enable writes and a registered read port
module dpram_be_bank_mem #(
  parameter int DW = 64,
  parameter int NW = 512,
  parameter int PAW = 9
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic [PAW-1:0]  waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wbe,
  input  logic            re,
  input  logic [PAW-1:0]  raddr,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [NW];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < DW/8; i++)
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/dpram_pingpong_buffer.sv
// dpram_pingpong_buffer: N-bank producer/consumer staging buffer with done/ready bank handover
module dpram_pingpong_buffer
  import dpram_pingpong_buffer_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 8,
  parameter int DEPTH = 256,
  parameter int N_BANK = 2,
  parameter int N_DELAY = 1,
  localparam int BW = bank_bits(N_BANK)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_be,
  input  logic            wr_done,
  output logic            wr_ready,
  output logic [BW-1:0]   wr_bank,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic            rd_done,
  output logic            rd_ready,
  output logic [BW-1:0]   rd_bank,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic [BW:0]     fill_cnt
);
  localparam int NW = N_BANK * DEPTH;
  localparam int PAW = bank_bits(NW);
  if (!dw_bytes_ok(DW)) begin : g_bad_dw
    $error("DW must be a positive multiple of 8");
  end
  if (N_DELAY < N_DELAY_MIN || N_DELAY > N_DELAY_MAX) begin : g_bad_delay
    $error("N_DELAY out of range 1..4");
  end
  if (N_BANK < 1 || N_BANK > N_BANK_MAX) begin : g_bad_bank
    $error("N_BANK out of range 1..8");
  end
  if (DEPTH < 1 || DEPTH > (1 << AW)) begin : g_bad_depth
    $error("DEPTH must be 1..2^AW");
  end
  logic [BW-1:0]      wr_ptr, rd_ptr;
  logic [BW:0]        fill;
  logic               wr_adv, rd_adv, wr_acc, rd_acc;
  logic [N_DELAY-1:0] vld;
  logic [DW-1:0]      mem_q;
  logic [PAW-1:0]     waddr, raddr;
  function automatic logic [BW-1:0] nxt(input logic [BW-1:0] p);
    return (p == BW'(N_BANK - 1)) ? '0 : p + 1'b1;
  endfunction
  assign wr_ready = fill < (BW+1)'(N_BANK);
  assign rd_ready = fill != '0;
  assign wr_bank  = wr_ptr;
  assign rd_bank  = rd_ptr;
  assign fill_cnt = fill;
  assign rd_valid = vld[N_DELAY-1];
  assign wr_adv   = wr_done && wr_ready;
  assign rd_adv   = rd_done && rd_ready;
  assign wr_acc   = wr_en && wr_ready && ({1'b0, wr_addr} < (AW+1)'(DEPTH));
  assign rd_acc   = rd_en && rd_ready;
  // Banks are laid out back to back, so DEPTH need not be a power of two
  assign waddr = PAW'(wr_ptr) * PAW'(DEPTH) + PAW'(wr_addr);
  assign raddr = PAW'(rd_ptr) * PAW'(DEPTH) + PAW'(rd_addr);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      vld    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      vld    <= '0;
    end else begin
      if (wr_adv) wr_ptr <= nxt(wr_ptr);
      if (rd_adv) rd_ptr <= nxt(rd_ptr);
      fill <= fill + (BW+1)'(wr_adv) - (BW+1)'(rd_adv);
      vld  <= N_DELAY'({vld, rd_acc});
    end
  dpram_be_bank_mem #(.DW(DW), .NW(NW), .PAW(PAW)) u_mem (
    .clk(clk), .rstn(rstn),
    .we(wr_acc), .waddr(waddr), .wdata(wr_data), .wbe(wr_be),
    .re(rd_acc), .raddr(raddr), .rdata(mem_q)
  );
  // Later stages only load behind a valid, so rd_data holds between reads
  if (N_DELAY == 1) begin : g_d1
    assign rd_data = mem_q;
  end else begin : g_dn
    logic [DW-1:0] dp [N_DELAY-1];
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
        for (int i = 0; i < N_DELAY-1; i++) dp[i] <= '0;
      end else begin
        if (vld[0]) dp[0] <= mem_q;
        for (int i = 1; i < N_DELAY-1; i++) if (vld[i]) dp[i] <= dp[i-1];
      end
    assign rd_data = dp[N_DELAY-2];
  end
endmodule

// File: tb/tb_dpram_pingpong_buffer.sv
// tb_dpram_pingpong_buffer: directed scenarios for the 2-bank, 3-cycle-latency configuration
module tb_dpram_pingpong_buffer;
  localparam int DW = 64, AW = 8, DEPTH = 256, N_BANK = 2, N_DELAY = 3, BW = 1;
  logic clk = 1'b0, rstn = 1'b0, flush = 1'b0;
  logic wr_en = 1'b0, wr_done = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW/8-1:0] wr_be = '0;
  logic wr_ready, rd_ready, rd_valid;
  logic [BW-1:0] wr_bank, rd_bank;
  logic [DW-1:0] rd_data;
  logic [BW:0] fill_cnt;
  int checks = 0, errors = 0;

  dpram_pingpong_buffer #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .N_BANK(N_BANK), .N_DELAY(N_DELAY)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_done(wr_done),
    .wr_ready(wr_ready), .wr_bank(wr_bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_ready(rd_ready), .rd_bank(rd_bank), .rd_data(rd_data), .rd_valid(rd_valid),
    .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    {flush, wr_en, wr_done, rd_en, rd_done} = '0;
    wr_be = '0;
  endtask

  task automatic test_reset;
    idle();
    rstn = 1'b0;
    repeat (2) tick();
    checks += 7;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready got %b exp 0", rd_ready); end
    if (wr_bank !== 1'b0) begin errors++; $display("FAIL reset_wr_bank got %h exp 0", wr_bank); end
    if (rd_bank !== 1'b0) begin errors++; $display("FAIL reset_rd_bank got %h exp 0", rd_bank); end
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    if (fill_cnt !== 2'd0) begin errors++; $display("FAIL reset_fill_cnt got %0d exp 0", fill_cnt); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_fill_read;
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i); wr_be = '1; wr_done = (i == 255);
      tick();
    end
    idle();
    checks += 4;
    if (wr_bank !== 1'b1) begin errors++; $display("FAIL fill_wr_bank got %h exp 1", wr_bank); end
    if (fill_cnt !== 2'd1) begin errors++; $display("FAIL fill_cnt got %0d exp 1", fill_cnt); end
    if (rd_ready !== 1'b1) begin errors++; $display("FAIL fill_rd_ready got %b exp 1", rd_ready); end
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL fill_wr_ready got %b exp 1", wr_ready); end
    rd_en = 1'b1; rd_addr = 8'd5;
    for (int n = 1; n <= 4; n++) begin
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_valid !== (n == 3)) begin errors++; $display("FAIL lat_valid_c%0d got %b exp %b", n, rd_valid, n == 3); end
    end
    checks += 1;
    if (rd_data !== 64'd5) begin errors++; $display("FAIL read_addr5 got %h exp 5", rd_data); end
    rd_en = 1'b1; rd_addr = 8'd255;
    tick(); rd_en = 1'b0; tick(); tick();
    checks += 2;
    if (rd_valid !== 1'b1) begin errors++; $display("FAIL read_addr255_valid got %b exp 1", rd_valid); end
    if (rd_data !== 64'd255) begin errors++; $display("FAIL write_with_done got %h exp ff", rd_data); end
  endtask

  task automatic test_byte_enable;
    wr_en = 1'b1; wr_addr = 8'd10; wr_data = 64'h1111_1111_2222_2222; wr_be = 8'hFF;
    tick();
    wr_data = 64'hAAAA_AAAA_BBBB_BBBB; wr_be = 8'h0F; wr_done = 1'b1;
    tick();
    idle();
    checks += 3;
    if (fill_cnt !== 2'd2) begin errors++; $display("FAIL full_fill_cnt got %0d exp 2", fill_cnt); end
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %b exp 0", wr_ready); end
    if (wr_bank !== 1'b0) begin errors++; $display("FAIL full_wr_bank got %h exp 0", wr_bank); end
    wr_en = 1'b1; wr_addr = 8'd0; wr_data = 64'hFF; wr_be = 8'hFF;
    tick();
    idle(); wr_done = 1'b1;
    tick();
    idle();
    checks += 2;
    if (fill_cnt !== 2'd2) begin errors++; $display("FAIL full_done_ignored got %0d exp 2", fill_cnt); end
    if (wr_bank !== 1'b0) begin errors++; $display("FAIL full_done_bank got %h exp 0", wr_bank); end
    rd_en = 1'b1; rd_addr = 8'd0;
    tick(); rd_en = 1'b0; tick(); tick();
    checks++;
    if (rd_data !== 64'd0) begin errors++; $display("FAIL full_write_ignored got %h exp 0", rd_data); end
    rd_done = 1'b1;
    tick();
    idle();
    checks += 3;
    if (fill_cnt !== 2'd1) begin errors++; $display("FAIL rd_done_fill got %0d exp 1", fill_cnt); end
    if (rd_bank !== 1'b1) begin errors++; $display("FAIL rd_done_bank got %h exp 1", rd_bank); end
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL rd_done_wr_ready got %b exp 1", wr_ready); end
    rd_en = 1'b1; rd_addr = 8'd10;
    tick(); rd_en = 1'b0; tick(); tick();
    checks++;
    if (rd_data !== 64'h1111_1111_BBBB_BBBB) begin errors++; $display("FAIL byte_enable got %h exp 11111111bbbbbbbb", rd_data); end
  endtask

  task automatic test_simul_done;
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = 64'h33; wr_be = 8'hFF; wr_done = 1'b1; rd_done = 1'b1;
    tick();
    idle();
    checks += 3;
    if (fill_cnt !== 2'd1) begin errors++; $display("FAIL simul_fill got %0d exp 1", fill_cnt); end
    if (wr_bank !== 1'b1) begin errors++; $display("FAIL simul_wr_bank got %h exp 1", wr_bank); end
    if (rd_bank !== 1'b0) begin errors++; $display("FAIL simul_rd_wrap got %h exp 0", rd_bank); end
    rd_en = 1'b1; rd_addr = 8'd3;
    tick(); rd_en = 1'b0; tick(); tick();
    checks++;
    if (rd_data !== 64'h33) begin errors++; $display("FAIL simul_data got %h exp 33", rd_data); end
  endtask

  task automatic test_back_to_back;
    for (int n = 1; n <= 7; n++) begin
      rd_en = (n <= 3); rd_addr = AW'(n + 4); rd_done = (n == 3);
      tick();
      rd_en = 1'b0; rd_done = 1'b0;
      checks++;
      if (rd_valid !== (n >= 3 && n <= 5)) begin errors++; $display("FAIL b2b_valid_c%0d got %b exp %b", n, rd_valid, n >= 3 && n <= 5); end
      if (n >= 3 && n <= 5) begin
        checks++;
        if (rd_data !== DW'(n + 2)) begin errors++; $display("FAIL b2b_data_c%0d got %h exp %h", n, rd_data, DW'(n + 2)); end
      end
    end
    checks += 2;
    if (fill_cnt !== 2'd0) begin errors++; $display("FAIL b2b_fill got %0d exp 0", fill_cnt); end
    if (rd_ready !== 1'b0) begin errors++; $display("FAIL b2b_rd_ready got %b exp 0", rd_ready); end
    for (int n = 1; n <= 6; n++) begin
      rd_en = (n <= 2); rd_done = (n <= 2); rd_addr = 8'd5;
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL empty_read_c%0d got %b exp 0", n, rd_valid); end
    end
    idle();
    checks += 2;
    if (fill_cnt !== 2'd0) begin errors++; $display("FAIL empty_done_fill got %0d exp 0", fill_cnt); end
    if (rd_bank !== 1'b1) begin errors++; $display("FAIL empty_done_bank got %h exp 1", rd_bank); end
  endtask

  task automatic test_flush;
    wr_en = 1'b1; wr_addr = 8'd40; wr_data = 64'h4141; wr_be = 8'hFF; wr_done = 1'b1;
    tick();
    wr_data = 64'h4040;
    tick();
    idle();
    checks += 2;
    if (fill_cnt !== 2'd2) begin errors++; $display("FAIL pre_flush_fill got %0d exp 2", fill_cnt); end
    if (wr_bank !== 1'b1) begin errors++; $display("FAIL pre_flush_wr_bank got %h exp 1", wr_bank); end
    flush = 1'b1; rd_done = 1'b1;
    tick();
    idle();
    checks += 5;
    if (fill_cnt !== 2'd0) begin errors++; $display("FAIL flush_fill got %0d exp 0", fill_cnt); end
    if (wr_bank !== 1'b0) begin errors++; $display("FAIL flush_wr_bank got %h exp 0", wr_bank); end
    if (rd_bank !== 1'b0) begin errors++; $display("FAIL flush_rd_bank got %h exp 0", rd_bank); end
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL flush_wr_ready got %b exp 1", wr_ready); end
    if (rd_ready !== 1'b0) begin errors++; $display("FAIL flush_rd_ready got %b exp 0", rd_ready); end
    wr_done = 1'b1;
    tick();
    idle();
    rd_en = 1'b1; rd_addr = 8'd40;
    tick(); rd_addr = 8'd3; tick(); rd_en = 1'b0; tick();
    checks++;
    if (rd_data !== 64'h4040) begin errors++; $display("FAIL flush_keep_40 got %h exp 4040", rd_data); end
    tick();
    checks++;
    if (rd_data !== 64'h33) begin errors++; $display("FAIL flush_keep_3 got %h exp 33", rd_data); end
    rd_en = 1'b1; rd_addr = 8'd40;
    tick();
    rd_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_pipe_c%0d got %b exp 0", n, rd_valid); end
      tick();
    end
    wr_done = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset_mid;
    for (int n = 1; n <= 4; n++) begin
      rd_en = 1'b1; rd_addr = 8'd40;
      tick();
      if (n >= 3) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 64'h4040) begin errors++; $display("FAIL burst_c%0d got %b/%h exp 1/4040", n, rd_valid, rd_data); end
      end
    end
    #2 rstn = 1'b0;
    #1;
    checks += 3;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", rd_valid); end
    if (fill_cnt !== 2'd0) begin errors++; $display("FAIL rst_mid_fill got %0d exp 0", fill_cnt); end
    if (rd_data !== 64'h0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", rd_data); end
    idle();
    tick();
    rstn = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_late_valid_c%0d got %b exp 0", n, rd_valid); end
    end
    checks++;
    if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 10", wr_ready, rd_ready); end
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_byte_enable();
    test_simul_done();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
